alu_cmd_ctrl: RTL and testbench

Command sequencer between the UART byte streams and the 32-bit ALU datapath. It parses length-prefixed command packets from the RX byte stream and either echoes the payload or folds 32-bit operands through the ALU. Folding uses a valid/ready request and result handshake. The 4-byte result is returned on the TX byte stream. It sits between the UART RX/TX cores inside the top-level echo/ALU design.

---
 rtl/alu_cmd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer: parses length-prefixed packets from the RX byte stream,
// echoes payload or folds 32-bit operands through an external ALU, returns result on TX.
module alu_cmd_ctrl #(
  parameter logic [7:0] OPC_ECHO = 8'hEC,
  parameter logic [7:0] OPC_ADD  = 8'hAD,
  parameter logic [7:0] OPC_MUL  = 8'h88
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_result_valid_i,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [3:0] {
    S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_ECHO,
    S_OPND, S_ALU_REQ, S_ALU_WAIT, S_TX_RES, S_DRAIN
  } state_e;

  state_e      state_q;
  logic [7:0]  opc_q;
  logic [7:0]  len_lo_q;
  logic [15:0] cnt_q;
  logic [31:0] acc_q;
  logic [31:0] opnd_q;
  logic [1:0]  idx_q;
  logic        first_q;
  logic        pend_q;
  logic        err_q;

  logic        rx_rdy, tx_vld, alu_vld;
  logic [7:0]  tx_dat;
  logic        rx_fire, tx_fire;
  logic [15:0] len_w, pay_len, cnt_dec;
  logic [31:0] opnd_d;
  logic        is_fold;

  assign len_w   = {rx_data_i, len_lo_q};
  assign pay_len = (len_w < 16'd4) ? '0 : len_w - 16'd4;
  assign cnt_dec = cnt_q - 16'd1;
  assign opnd_d  = {rx_data_i, opnd_q[31:8]};
  assign is_fold = (opc_q == OPC_ADD) || (opc_q == OPC_MUL);

  always_comb begin
    rx_rdy  = 1'b0;
    tx_vld  = 1'b0;
    tx_dat  = '0;
    alu_vld = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_OPND, S_DRAIN: rx_rdy = 1'b1;
      S_ECHO: begin
        rx_rdy = tx_ready_i;
        tx_vld = rx_valid_i;
        tx_dat = rx_data_i;
      end
      S_ALU_REQ: alu_vld = 1'b1;
      S_TX_RES: begin
        tx_vld = 1'b1;
        tx_dat = acc_q[{idx_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  assign rx_fire = rx_valid_i && rx_rdy;
  assign tx_fire = tx_vld && tx_ready_i;

  // After an operand is folded: more whole operands, a ragged tail to drain, or done.
  function automatic state_e fold_next(input logic [15:0] rem);
    if (rem >= 16'd4) return S_OPND;
    if (rem != '0)    return S_DRAIN;
    return S_TX_RES;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_HDR0;
      opc_q    <= '0;
      len_lo_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      pend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_HDR0: if (rx_fire) begin
          opc_q   <= rx_data_i;
          state_q <= S_HDR1;
        end
        S_HDR1: if (rx_fire) state_q <= S_HDR2;
        S_HDR2: if (rx_fire) begin
          len_lo_q <= rx_data_i;
          state_q  <= S_HDR3;
        end
        S_HDR3: if (rx_fire) begin
          cnt_q   <= pay_len;
          idx_q   <= '0;
          first_q <= 1'b1;
          acc_q   <= '0;
          pend_q  <= is_fold;
          if (opc_q == OPC_ECHO) begin
            state_q <= (pay_len != '0) ? S_ECHO : S_HDR0;
          end else if (is_fold) begin
            state_q <= fold_next(pay_len);
          end else begin
            err_q   <= 1'b1;
            state_q <= (pay_len != '0) ? S_DRAIN : S_HDR0;
          end
        end
        S_ECHO: if (rx_fire) begin
          cnt_q <= cnt_dec;
          if (cnt_q == 16'd1) state_q <= S_HDR0;
        end
        S_OPND: if (rx_fire) begin
          opnd_q <= opnd_d;
          idx_q  <= idx_q + 2'd1;
          cnt_q  <= cnt_dec;
          if (idx_q == 2'd3) begin
            if (first_q) begin
              acc_q   <= opnd_d;
              first_q <= 1'b0;
              state_q <= fold_next(cnt_dec);
            end else begin
              state_q <= S_ALU_REQ;
            end
          end
        end
        S_ALU_REQ: if (alu_ready_i) state_q <= S_ALU_WAIT;
        S_ALU_WAIT: if (alu_result_valid_i) begin
          acc_q   <= alu_result_i;
          state_q <= fold_next(cnt_q);
        end
        S_TX_RES: if (tx_fire) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= S_HDR0;
        end
        S_DRAIN: if (rx_fire) begin
          cnt_q <= cnt_dec;
          if (cnt_q == 16'd1) state_q <= pend_q ? S_TX_RES : S_HDR0;
        end
        default: state_q <= S_HDR0;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held, not just after the edge.
  assign rx_ready_o  = rst_ni & rx_rdy;
  assign tx_valid_o  = rst_ni & tx_vld;
  assign tx_data_o   = rst_ni ? tx_dat : '0;
  assign alu_valid_o = rst_ni & alu_vld;
  assign alu_op_o    = (rst_ni && opc_q == OPC_MUL) ? 2'b01 : 2'b00;
  assign alu_a_o     = rst_ni ? acc_q : '0;
  assign alu_b_o     = rst_ni ? opnd_q : '0;
  assign busy_o      = rst_ni && (state_q != S_HDR0);
  assign err_o       = rst_ni & err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomised scoreboard bench for alu_cmd_ctrl with a packet-level reference model
// and a behavioural ALU stub.
module tb_alu_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready;
  logic [31:0] alu_res;
  logic        alu_res_valid;
  logic        busy_o;
  logic        err_o;

  alu_cmd_ctrl dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .rx_data_i          (rx_data),
    .rx_valid_i         (rx_valid),
    .rx_ready_o         (rx_ready_o),
    .tx_data_o          (tx_data_o),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready),
    .alu_op_o           (alu_op_o),
    .alu_a_o            (alu_a_o),
    .alu_b_o            (alu_b_o),
    .alu_valid_o        (alu_valid_o),
    .alu_ready_i        (alu_ready),
    .alu_result_i       (alu_res),
    .alu_result_valid_i (alu_res_valid),
    .busy_o             (busy_o),
    .err_o              (err_o)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  logic [7:0]  exp_tx[$];
  alu_req_t    exp_alu[$];
  int          exp_err = 0;
  int          got_err = 0;
  int          errors  = 0;
  int          checks  = 0;

  bit          alu_auto = 1'b1;
  int          alu_dly_fix = -1;
  bit          res_pend = 1'b0;
  int          res_dly = 0;
  logic [31:0] res_val = '0;
  bit          rand_tx = 1'b0;
  bit          gap_en = 1'b0;
  int          stall = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-packet semantics computed with plain arithmetic.
  task automatic model(input logic [7:0] p[$]);
    logic [15:0] len, pl;
    logic [31:0] acc, w;
    int          n;
    len = {p[3], p[2]};
    pl  = (len < 16'd4) ? 16'd0 : len - 16'd4;
    if (p[0] == 8'hEC) begin
      for (int i = 0; i < int'(pl); i++) exp_tx.push_back(p[4+i]);
    end else if (p[0] == 8'hAD || p[0] == 8'h88) begin
      acc = '0;
      n   = int'(pl) / 4;
      for (int k = 0; k < n; k++) begin
        w = {p[7+4*k], p[6+4*k], p[5+4*k], p[4+4*k]};
        if (k == 0) acc = w;
        else begin
          exp_alu.push_back('{op: (p[0] == 8'h88) ? 2'b01 : 2'b00, a: acc, b: w});
          acc = (p[0] == 8'hAD) ? acc + w : acc * w;
        end
      end
      for (int i = 0; i < 4; i++) exp_tx.push_back(acc[8*i +: 8]);
    end else begin
      exp_err++;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int t;
    if (gap_en) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = rx_ready_o;
      @(posedge clk); #1;
      t++;
    end
    rx_valid = 1'b0;
    chk("rx_accept_timeout", ok, 1'b1);
  endtask

  task automatic send_packet(input logic [7:0] p[$], input bit use_model);
    if (use_model) model(p);
    foreach (p[i]) send_byte(p[i]);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((busy_o || exp_tx.size() != 0) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    @(negedge clk);
    chk(nm, {busy_o, 31'(exp_tx.size())}, '0);
    @(posedge clk); #1;
  endtask

  // Monitor: TX scoreboard, ALU request scoreboard, error pulse counter.
  initial begin
    logic [7:0] e;
    alu_req_t   r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (err_o) got_err++;
        if (tx_valid_o && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got %02h expected no byte", tx_data_o);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", tx_data_o, e);
          end
        end
        if (alu_valid_o && alu_ready) begin
          if (exp_alu.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL alu_unexpected: got op=%0h a=%0h b=%0h expected no request",
                     alu_op_o, alu_a_o, alu_b_o);
          end else begin
            r = exp_alu.pop_front();
            chk("alu_req", {alu_op_o, alu_a_o, alu_b_o}, r);
          end
          if (alu_auto) begin
            res_val  = (alu_op_o == 2'b01) ? alu_a_o * alu_b_o : alu_a_o + alu_b_o;
            res_dly  = (alu_dly_fix >= 0) ? alu_dly_fix : int'($urandom_range(0, 5));
            res_pend = 1'b1;
          end
        end
      end
    end
  end

  // Behavioural ALU stub.
  initial begin
    alu_ready     = 1'b0;
    alu_res_valid = 1'b0;
    alu_res       = '0;
    forever begin
      @(posedge clk); #1;
      if (alu_auto) begin
        alu_res_valid = 1'b0;
        if (res_pend) begin
          if (res_dly == 0) begin
            alu_res_valid = 1'b1;
            alu_res       = res_val;
            res_pend      = 1'b0;
          end else res_dly--;
        end
        alu_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        tx_ready = 1'b0;
        stall--;
      end else tx_ready = rand_tx ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    logic [7:0]  pkt[$];
    logic [15:0] len, pl;
    logic [7:0]  opc;
    int          e0, t;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o,
                          alu_a_o, alu_b_o, busy_o, err_o}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {rx_ready_o, busy_o}, 2'b10);
    @(posedge clk); #1;

    // Echo with a 3-cycle TX stall mid-stream
    pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    fork
      send_packet(pkt, 1'b1);
      begin repeat (5) @(posedge clk); stall = 3; end
    join
    wait_idle("echo_idle");

    alu_dly_fix = 5;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_packet(pkt, 1'b1);
    wait_idle("add_idle");
    alu_dly_fix = -1;

    pkt = '{8'h88, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
            8'h00, 8'h00, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_packet(pkt, 1'b1);
    wait_idle("mul_idle");
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    send_packet(pkt, 1'b1);
    wait_idle("addwrap_idle");

    pkt = '{8'hAD, 8'h00, 8'h04, 8'h00};
    send_packet(pkt, 1'b1);
    wait_idle("len4_idle");
    pkt = '{8'hAD, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
    send_packet(pkt, 1'b1);
    wait_idle("len6_idle");
    pkt = '{8'hAD, 8'h00, 8'h09, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'hFF};
    send_packet(pkt, 1'b1);
    wait_idle("len9_idle");

    e0 = got_err;
    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
    send_packet(pkt, 1'b1);
    wait_idle("unknown_idle");
    chk("err_pulse_once", 32'(got_err - e0), 32'd1);
    pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_packet(pkt, 1'b1);
    wait_idle("echo_after_err_idle");

    // Reset while waiting for the ALU result; a late result must be ignored.
    alu_auto  = 1'b0;
    alu_ready = 1'b0;
    exp_alu.push_back('{op: 2'b00, a: 32'd1, b: 32'd2});
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_packet(pkt, 1'b0);
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (alu_valid_o) break;
      @(posedge clk); #1;
      t++;
    end
    chk("alu_req_seen", alu_valid_o, 1'b1);
    @(posedge clk); #1;
    alu_ready = 1'b1;
    @(posedge clk); #1;
    alu_ready = 1'b0;
    @(negedge clk);
    chk("alu_wait_busy", {busy_o, alu_valid_o}, 2'b10);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_reset_outputs", {rx_ready_o, tx_valid_o, tx_data_o, alu_valid_o, alu_op_o,
                                alu_a_o, alu_b_o, busy_o, err_o}, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n         = 1'b1;
    alu_res_valid = 1'b1;
    alu_res       = 32'hDEADBEEF;
    @(posedge clk); #1;
    alu_res_valid = 1'b0;
    @(negedge clk);
    chk("late_result_ignored", {rx_ready_o, tx_valid_o, busy_o, alu_a_o}, {3'b100, 32'd0});
    @(posedge clk); #1;
    alu_auto = 1'b1;
    pkt = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    send_packet(pkt, 1'b1);
    wait_idle("post_reset_add_idle");

    rand_tx = 1'b1;
    gap_en  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: opc = 8'hEC;
        1: opc = 8'hAD;
        2: opc = 8'h88;
        default: opc = 8'($urandom);
      endcase
      len = 16'($urandom_range(0, 22));
      pl  = (len < 16'd4) ? 16'd0 : len - 16'd4;
      pkt.delete();
      pkt.push_back(opc);
      pkt.push_back(8'($urandom));
      pkt.push_back(len[7:0]);
      pkt.push_back(len[15:8]);
      for (int i = 0; i < int'(pl); i++) pkt.push_back(8'($urandom));
      send_packet(pkt, 1'b1);
    end
    wait_idle("random_idle");

    chk("alu_queue_empty", 32'(exp_alu.size()), 32'd0);
    chk("err_count", 32'(got_err), 32'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
